frame_bank_sched: RTL

FRAME_BANK_SCHED -- requirements
Module: frame_bank_sched

---
 rtl/frame_bank_sched.sv | 122 ++++++++++++
 1 files changed

// File: rtl/frame_bank_sched.sv
// Ping-pong frame cache scheduler: tracks which of two banks hold a complete frame,
// hands full banks to the cell fetcher, and counts cells out until the frame is consumed.
module frame_bank_sched #(
    parameter int CELL_NUM = 1200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_i,
    input  logic        wr_frame_done_i,
    output logic        wr_bank_o,
    output logic        wr_bank_rdy_o,
    output logic        rd_bank_o,
    output logic        cell_fetch_start_o,
    input  logic        fwd_hs_i,
    output logic        frame_done_o,
    output logic        busy_o,
    output logic [15:0] frame_cnt_o,
    output logic        drop_err_o,
    output logic [1:0]  state_dbg_o
);

    localparam int CNT_W = (CELL_NUM > 1) ? $clog2(CELL_NUM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CELL_NUM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        FETCH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [1:0]       full, full_n;
    logic             wr_bank, rd_bank;
    logic [CNT_W-1:0] cell_cnt, cell_cnt_n;
    logic [15:0]      frame_cnt;
    logic             drop_err;
    logic             start_pulse, done_pulse;
    logic             wr_accept, wr_drop;

    // Handshakes: wr_frame_done_i is accepted only when wr_bank_rdy_o is high in
    // the same cycle (otherwise it is dropped and flagged); fwd_hs_i is already the
    // valid&ready product and counts one cell only while the FSM is in FETCH.
    assign wr_accept = wr_frame_done_i & ~full[wr_bank];
    assign wr_drop   = wr_frame_done_i &  full[wr_bank];

    always_comb begin
        state_n     = state;
        cell_cnt_n  = cell_cnt;
        start_pulse = 1'b0;
        done_pulse  = 1'b0;
        case (state)
            IDLE: begin
                if (enable_i && full[rd_bank])
                    state_n = START;
            end
            START: begin
                start_pulse = 1'b1;
                cell_cnt_n  = '0;
                state_n     = FETCH;
            end
            FETCH: begin
                if (fwd_hs_i) begin
                    if (cell_cnt == CNT_LAST)
                        state_n = DONE;
                    else
                        cell_cnt_n = cell_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                done_pulse = 1'b1;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Writer set and reader release never collide: the writer can only fill an empty bank.
    always_comb begin
        full_n = full;
        if (wr_accept)
            full_n[wr_bank] = 1'b1;
        if (done_pulse)
            full_n[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            full      <= 2'b00;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            cell_cnt  <= '0;
            frame_cnt <= 16'd0;
            drop_err  <= 1'b0;
        end else begin
            state    <= state_n;
            full     <= full_n;
            cell_cnt <= cell_cnt_n;
            if (wr_accept)
                wr_bank <= ~wr_bank;
            if (done_pulse) begin
                rd_bank   <= ~rd_bank;
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (wr_drop)
                drop_err <= 1'b1;
        end
    end

    // Outputs are forced to their reset values while rst is held, even before the first edge.
    assign wr_bank_o          = wr_bank;
    assign rd_bank_o          = rd_bank;
    assign wr_bank_rdy_o      = rst | ~full[wr_bank];
    assign cell_fetch_start_o = start_pulse & ~rst;
    assign frame_done_o       = done_pulse & ~rst;
    assign busy_o             = (state != IDLE) & ~rst;
    assign frame_cnt_o        = frame_cnt;
    assign drop_err_o         = drop_err;
    assign state_dbg_o        = state;

endmodule
